sobel_window_feeder: RTL and testbench
======================================

Name: sobel_window_feeder

Overview:
- Drives the Sobel engine's input side.
- Reads a grayscale frame from a frame memory with 1-cycle read latency.
- Streams pixels in 3-pixel column vectors, band by band, using the engine's start/pixel/finish cadence.
- Counts the engine's px_ready pulses to close each band, then reports frame completion. Sits between the grayscale frame buffer and the Sobel engine.

Parameters:
- PIXEL_WIDTH, 8, gray pixel width.
- IMG_WIDTH, 640, frame width in pixels (must be ≥3).
- IMG_HEIGHT, 480, frame height in pixels (must be ≥3).
- ADDR_WIDTH, 19, frame-memory address width (must be ≥ clog2(IMG_WIDTH*IMG_HEIGHT)).

Ports:
- clk_i  in  1  clock.
- nreset_i  in  1  asynchronous active-low reset.
- frame_start_i  in  1  one-cycle request to process a frame; ignored while busy_o=1.
- rd_en_o  out  1  memory read strobe.
- rd_addr_o  out  ADDR_WIDTH  read address = row*IMG_WIDTH + col.
- rd_data_i  in  PIXEL_WIDTH  read data, valid the cycle after rd_en_o.
- px_o  out  PIXEL_WIDTH  pixel to engine (registered).
- px_valid_o  out  1  px_o holds a pixel slot (bench/debug qualifier).
- start_o  out  1  one-cycle engine start per band.
- finish_o  out  1  one-cycle engine finish per band.
- px_ready_i  in  1  engine result strobe.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse after the last band's finish.

Behaviour:
- Reset (async, nreset_i=0):
  - State IDLE.
  - All outputs 0: rd_en_o, rd_addr_o, px_o, px_valid_o, start_o, finish_o, busy_o, frame_done_o.
  - All counters 0.
  - Reset mid-frame abandons the frame; no finish_o is issued.
- Band b covers rows b..b+2, for b=0..IMG_HEIGHT-3. Column vector c = pixels (b,c), (b+1,c), (b+2,c), in that order, for c=0..IMG_WIDTH-1.
- States: IDLE -> PREFETCH -> START -> FEED -> WAIT_RES -> FINISH -> GAP -> (PREFETCH for next band | DONE) -> IDLE.
  - IDLE: frame_start_i=1 -> PREFETCH, busy_o<=1, band=0.
  - PREFETCH (1 cycle): issues the read for (b,0).
  - START: start_o=1 for exactly one cycle; call this cycle S.
  - FEED, first window: pixels of columns 0,1,2 occupy cycles S+1..S+9 back to back, px_valid_o=1.
  - FEED, steady state: for each column c≥3, one bubble cycle (px_valid_o=0, px_o=0) is followed by 3 pixel cycles. Column c's first pixel is at cycle S+11+4*(c-3).
  - Read pipeline: rd_en_o is asserted exactly 2 cycles before each pixel slot. rd_data_i is registered into px_o. No reads are issued in bubble cycles or outside FEED/PREFETCH.
  - After the last pixel of column IMG_WIDTH-1 -> WAIT_RES.
  - Result counting: px_ready_i pulses are counted throughout FEED/WAIT_RES. When the count reaches IMG_WIDTH-2 -> FINISH (the cycle after that pulse is seen).
  - FINISH: finish_o=1 for one cycle, then GAP (1 cycle, all strobes 0).
  - GAP: if b<IMG_HEIGHT-3, then b+1 and -> PREFETCH; else -> DONE.
  - DONE: frame_done_o=1 for one cycle, busy_o<=0 -> IDLE.
  - px_ready_i outside FEED/WAIT_RES is ignored.
- Addressing:
  - Computed incrementally from a band base address (b*IMG_WIDTH) plus col + k*IMG_WIDTH for k=0..2. No multiplier.
  - Max address = IMG_WIDTH*IMG_HEIGHT-1. There is no wrap.
- Timing/throughput:
  - Per band: 9 + 4*(IMG_WIDTH-3) pixel/bubble cycles, plus start, finish, gap, prefetch and result latency.
  - start_o is never within 2 cycles after finish_o.
  - start_o and finish_o are never high together.
- Degenerate width IMG_WIDTH=3: the band has only the first window. finish_o is asserted the cycle after the single px_ready_i (S+11).
- frame_start_i while busy_o=1 has no effect. frame_start_i in the same cycle as frame_done_o is also ignored.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3; memory holds pixel value = address; frame_start_i pulse. Required response:
  - start_o once.
  - px_valid_o pixels 0,4,8,1,5,9,2,6,10 at S+1..S+9.
  - Bubble at S+10.
  - 3,7,11 at S+11..S+13.
  - frame_done_o once; busy_o low after.
- Same config with a model engine returning px_ready_i the cycle after each window's last pixel. Required response: finish_o exactly one cycle after the 2nd px_ready_i; no further start_o.
- IMG_WIDTH=5, IMG_HEIGHT=5. Required response:
  - 3 start_o/finish_o pairs.
  - Band 1 first pixel address 5.
  - Band 2 last pixel address 24.
  - Every rd_en_o precedes its px_valid_o slot by exactly 2 cycles.
  - 9 px_ready_i consumed; frame_done_o once.
- IMG_WIDTH=3, IMG_HEIGHT=3. Required response: 9 pixels, no bubbles after S+9; finish_o at S+11.
- Delayed px_ready_i (engine holds results 5 extra cycles). Required response: feeder stays in WAIT_RES with finish_o=0 until the count completes; then finish_o, gap, next start_o.
- nreset_i asserted mid-FEED of band 1. Required response:
  - All outputs 0 immediately, without waiting for a clock edge.
  - A new frame_start_i after release restarts at address 0, band 0.
  - A frame_start_i during an active frame is ignored (no second start_o sequence).

Source files
------------

// File: rtl/sobel_window_feeder.sv
// Sobel window feeder: walks a grayscale frame band by band (3 rows at a time)
// and streams 3-pixel column vectors to the Sobel engine.
module sobel_window_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   frame_start_i,
    output logic                   rd_en_o,
    output logic [ADDR_WIDTH-1:0]  rd_addr_o,
    input  logic [PIXEL_WIDTH-1:0] rd_data_i,
    output logic [PIXEL_WIDTH-1:0] px_o,
    output logic                   px_valid_o,
    output logic                   start_o,
    output logic                   finish_o,
    input  logic                   px_ready_i,
    output logic                   busy_o,
    output logic                   frame_done_o
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int BW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0]         LAST_COL   = CW'(IMG_WIDTH - 1);
    localparam logic [BW-1:0]         LAST_BAND  = BW'(IMG_HEIGHT - 3);
    localparam logic [CW:0]           RES_TARGET = (CW + 1)'(IMG_WIDTH - 2);
    localparam logic [ADDR_WIDTH-1:0] ROW1       = ADDR_WIDTH'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ROW2       = ADDR_WIDTH'(2 * IMG_WIDTH);

    typedef enum logic [2:0] {
        IDLE, PREFETCH, START, FEED, WAIT_RES, FINISH, GAP, DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [BW-1:0]          band;
    logic [ADDR_WIDTH-1:0]  base;
    logic [CW-1:0]          col;
    logic [1:0]             k;
    logic                   bubble, rd_done;
    logic [CW:0]            res_cnt, res_cnt_inc;
    logic                   res_hit, counting;
    logic                   rd_d1, last_d1, px_last, last_rd;
    logic [ADDR_WIDTH-1:0]  row_off;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_o      = 1'b0;
        finish_o     = 1'b0;
        frame_done_o = 1'b0;
        busy_o       = 1'b1;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (frame_start_i) state_nxt = PREFETCH;
            end
            PREFETCH: state_nxt = START;
            START: begin
                start_o   = 1'b1;
                state_nxt = FEED;
            end
            FEED:     if (px_last) state_nxt = WAIT_RES;
            WAIT_RES: if (res_hit) state_nxt = FINISH;
            FINISH: begin
                finish_o  = 1'b1;
                state_nxt = GAP;
            end
            GAP:  state_nxt = (band == LAST_BAND) ? DONE : PREFETCH;
            DONE: begin
                frame_done_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reads lead their pixel slot by two cycles, so the first two reads of a
    // band fall in PREFETCH and START; the rest follow the FEED slot pattern.
    always_comb begin
        rd_en_o   = (state == PREFETCH) || (state == START) ||
                    ((state == FEED) && !bubble && !rd_done);
        row_off   = (k == 2'd0) ? '0 : (k == 2'd1) ? ROW1 : ROW2;
        rd_addr_o = rd_en_o ? (base + ADDR_WIDTH'(col) + row_off) : '0;
        last_rd   = rd_en_o && (col == LAST_COL) && (k == 2'd2);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            band <= '0;
            base <= '0;
        end else if (state == IDLE) begin
            band <= '0;
            base <= '0;
        end else if ((state == GAP) && (band != LAST_BAND)) begin
            band <= band + BW'(1);
            base <= base + ROW1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col     <= '0;
            k       <= '0;
            bubble  <= 1'b0;
            rd_done <= 1'b0;
        end else if (rd_en_o) begin
            if (k == 2'd2) begin
                k       <= '0;
                col     <= col + CW'(1);
                // one idle slot before every column after the first window
                bubble  <= (col >= CW'(2)) && (col != LAST_COL);
                rd_done <= (col == LAST_COL);
            end else begin
                k <= k + 2'd1;
            end
        end else if (state == FEED) begin
            bubble <= 1'b0;
        end else begin
            col     <= '0;
            k       <= '0;
            bubble  <= 1'b0;
            rd_done <= 1'b0;
        end
    end

    always_comb begin
        counting    = (state == FEED) || (state == WAIT_RES);
        res_cnt_inc = res_cnt + {{CW{1'b0}}, px_ready_i && counting};
        res_hit     = res_cnt_inc >= RES_TARGET;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i)                               res_cnt <= '0;
        else if (state == PREFETCH)                  res_cnt <= '0;
        else if (counting && res_cnt != RES_TARGET)  res_cnt <= res_cnt_inc;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            rd_d1      <= 1'b0;
            last_d1    <= 1'b0;
            px_valid_o <= 1'b0;
            px_last    <= 1'b0;
            px_o       <= '0;
        end else begin
            rd_d1      <= rd_en_o;
            last_d1    <= last_rd;
            px_valid_o <= rd_d1;
            px_last    <= last_d1;
            px_o       <= rd_d1 ? rd_data_i : '0;
        end
    end
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Bench for sobel_window_feeder: three frame geometries, a pixel/timing
// scoreboard, a model engine with configurable result delay, and reset abort.
module tb_sobel_window_feeder;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NDUT-1:0] nreset, frame_start, px_ready;
    logic [NDUT-1:0] rd_en, px_valid, start, finish, busy, frame_done;
    logic [7:0]      rd_addr [NDUT];
    logic [7:0]      px      [NDUT];

    int WD [NDUT] = '{4, 5, 3};
    int HD [NDUT] = '{3, 5, 3};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : (g == 1) ? 5 : 3;
        localparam int H = (g == 1) ? 5 : 3;
        logic [7:0] mem_q;
        // frame memory holding pixel value = address, one cycle read latency
        always @(posedge clk) mem_q <= rd_en[g] ? rd_addr[g] : 8'hEE;
        sobel_window_feeder #(
            .PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(8)
        ) u_dut (
            .clk_i(clk), .nreset_i(nreset[g]), .frame_start_i(frame_start[g]),
            .rd_en_o(rd_en[g]), .rd_addr_o(rd_addr[g]), .rd_data_i(mem_q),
            .px_o(px[g]), .px_valid_o(px_valid[g]), .start_o(start[g]),
            .finish_o(finish[g]), .px_ready_i(px_ready[g]), .busy_o(busy[g]),
            .frame_done_o(frame_done[g])
        );
    end

    typedef struct { int val; int off; int col; int k; } slot_t;
    slot_t exp_q [$];
    int    rdy_q [$];
    int    cur, dly, s_cyc, last_fin, last_rdy, rdy_cnt, starts, finishes, dones;
    logic [1:0] rd_hist;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (dut %0d, cycle %0d)",
                     tag, act, exp, cur, cyc);
        end
    endtask

    function automatic int slot_off(input int c, input int k);
        return (c < 3) ? (1 + 3 * c + k) : (11 + 4 * (c - 3) + k);
    endfunction

    task automatic check_outputs_zero(input int d, input string pfx);
        check({pfx, "_rd_en"},      int'(rd_en[d]), 0);
        check({pfx, "_rd_addr"},    int'(rd_addr[d]), 0);
        check({pfx, "_px"},         int'(px[d]), 0);
        check({pfx, "_px_valid"},   int'(px_valid[d]), 0);
        check({pfx, "_start"},      int'(start[d]), 0);
        check({pfx, "_finish"},     int'(finish[d]), 0);
        check({pfx, "_busy"},       int'(busy[d]), 0);
        check({pfx, "_frame_done"}, int'(frame_done[d]), 0);
    endtask

    // One clock: drive the model engine, then score the outputs of this cycle.
    task automatic step();
        @(negedge clk);
        px_ready[cur] = 1'b0;
        if (rdy_q.size() > 0 && rdy_q[0] == cyc) begin
            void'(rdy_q.pop_front());
            px_ready[cur] = 1'b1;
            rdy_cnt++;
            last_rdy = cyc;
        end
        if (start[cur] || finish[cur])
            check("start_finish_excl", int'(start[cur] & finish[cur]), 0);
        if (start[cur]) begin
            if (last_fin >= 0) check("finish_to_start_gap", int'(cyc - last_fin >= 3), 1);
            starts++;
            s_cyc   = cyc;
            rdy_cnt = 0;
        end
        if (px_valid[cur] || rd_hist[1])
            check("rd_to_px_2cyc", int'(px_valid[cur]), int'(rd_hist[1]));
        if (px_valid[cur]) begin
            if (exp_q.size() == 0) begin
                check("px_unexpected", 1, 0);
            end else begin
                slot_t e;
                e = exp_q.pop_front();
                check("px_value", int'(px[cur]), e.val);
                check("px_slot", cyc - s_cyc, e.off);
                if (e.k == 2 && e.col >= 2) rdy_q.push_back(cyc + 1 + dly);
            end
        end else if (busy[cur]) begin
            check("bubble_px_zero", int'(px[cur]), 0);
        end
        if (finish[cur]) begin
            finishes++;
            check("finish_after_results", rdy_cnt, WD[cur] - 2);
            check("finish_latency", cyc - last_rdy, 1);
            check("finish_slot", cyc - s_cyc, slot_off(WD[cur] - 1, 2) + 2 + dly);
            last_fin = cyc;
        end
        if (frame_done[cur]) dones++;
        rd_hist = {rd_hist[0], rd_en[cur]};
    endtask

    task automatic start_frame(input int d, input int delay);
        cur = d;
        dly = delay;
        exp_q.delete();
        rdy_q.delete();
        s_cyc = 0; last_fin = -1; last_rdy = -100; rdy_cnt = 0;
        starts = 0; finishes = 0; dones = 0; rd_hist = '0;
        for (int b = 0; b <= HD[d] - 3; b++)
            for (int c = 0; c < WD[d]; c++)
                for (int k = 0; k < 3; k++)
                    exp_q.push_back('{(b + k) * WD[d] + c, slot_off(c, k), c, k});
        frame_start[d] = 1'b1;
        step();
        frame_start[d] = 1'b0;
        check("busy_after_start", int'(busy[d]), 1);
    endtask

    task automatic finish_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (i == 5) frame_start[cur] = 1'b1;   // must be ignored while busy
            step();
            frame_start[cur] = 1'b0;
            if (frame_done[cur]) begin
                seen = 1'b1;
                frame_start[cur] = 1'b1;           // same cycle as frame_done: ignored
                step();
                frame_start[cur] = 1'b0;
            end
        end
        check("frame_done_seen", int'(seen), 1);
        repeat (8) step();
        check("busy_low_after", int'(busy[cur]), 0);
        check("start_count", starts, HD[cur] - 2);
        check("finish_count", finishes, HD[cur] - 2);
        check("frame_done_count", dones, 1);
        check("pixels_left", exp_q.size(), 0);
        check("results_left", rdy_q.size(), 0);
    endtask

    initial begin
        nreset      = '0;
        frame_start = '0;
        px_ready    = '0;
        cur         = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            cur = d;
            check_outputs_zero(d, "reset");
        end
        nreset = '1;
        @(negedge clk);

        start_frame(0, 0); finish_frame();   // 4x3, engine answers next cycle
        start_frame(1, 5); finish_frame();   // 5x5, engine holds results 5 cycles
        start_frame(2, 0); finish_frame();   // 3x3, first window only

        start_frame(1, 0);
        for (int i = 0; i < 200 && starts < 2; i++) step();
        check("band1_reached", starts, 2);
        repeat (5) step();
        #2 nreset[1] = 1'b0;
        px_ready[1] = 1'b0;
        #1 check_outputs_zero(1, "async_reset");
        repeat (2) @(negedge clk);
        check_outputs_zero(1, "held_reset");
        nreset[1] = 1'b1;
        @(negedge clk);
        start_frame(1, 0); finish_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
